// File: rtl/seq_counter.sv
// seq_counter: parametrised sequencing counter for iterative datapath units
// (multiplier, divider, ...). Counts clock cycles from a start request until
// either the terminal count LAST is reached or an explicit stop arrives.
//
// Parameters:
//   WIDTH     counter width in bits (2..16)
//   LAST      terminal count, 1 <= LAST <= 2^WIDTH-1
//   AUTO_STOP 1: stop at LAST and pulse done; 0: wrap to 0, pulse wrap, keep running
//
// Ports:
//   clock    in   rising-edge clock
//   clr      in   asynchronous active-high reset
//   start    in   request a run (ignored while running)
//   stop     in   abort a run; dominates start and hold
//   hold     in   freeze the count while running (only with SEQ_COUNTER_HOLD_EN)
//   count    out  current step number
//   running  out  high while counting
//   done     out  one-cycle pulse on reaching LAST (AUTO_STOP=1)
//   wrap     out  one-cycle pulse on LAST->0 (AUTO_STOP=0)
//
// Optional feature macro: SEQ_COUNTER_HOLD_EN adds the hold input.
// All outputs come straight from registers; there is no input-to-output
// combinational path.

module seq_counter #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned LAST      = 31,
  parameter int unsigned AUTO_STOP = 1
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
`ifdef SEQ_COUNTER_HOLD_EN
  input  logic             hold,
`endif
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             wrap
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("seq_counter: WIDTH must be in 2..16");
  end
  if (LAST < 1 || LAST > ((32'd1 << WIDTH) - 32'd1)) begin : g_bad_last
    $error("seq_counter: LAST must be in 1..2^WIDTH-1");
  end

  localparam logic [WIDTH-1:0] LastW = LAST[WIDTH-1:0];

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             hold_w;

`ifdef SEQ_COUNTER_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  // Next-state logic. Pulses default to 0 so done/wrap self-clear after one
  // cycle in every path, including while held.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // stop dominates start; hold has no effect here.
        if (start && !stop) begin
          state_d = StRun;
          count_d = '0;
        end
      end

      StRun: begin
        if (stop) begin
          // Abort: count holds, no terminal pulse even at LAST.
          state_d = StIdle;
        end else if (hold_w) begin
          // Frozen: terminal check suspended, nothing advances.
          state_d = StRun;
        end else if (count_q != LastW) begin
          count_d = count_q + 1'b1;
        end else if (AUTO_STOP != 0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      count_q <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count   = count_q;
  assign running = (state_q == StRun);
  assign done    = done_q;
  assign wrap    = wrap_q;

endmodule
